btn_conditioner: RTL and testbench

Conditions the raw FPGA push-buttons before they reach the memory-mapped I/O block's `buttons_in` port, directly upstream of the CPU's button register. Each button gets a two-flop synchronizer and a per-channel debounce state machine. The block produces a clean level and a one-cycle press pulse per button, plus a sticky press-event flag the CPU clears through an I/O write. Rhythm-game input timing depends on these flags, so debounce latency is fixed and exact.

---
 rtl/btn_pkg.sv | 14 +
 rtl/btn_debounce_ch.sv | 111 +++++++++++
 rtl/btn_conditioner.sv | 47 ++++
 tb/tb_btn_conditioner.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS        = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_REPEAT_FIRST_MUL = 16;
  localparam int unsigned BTN_REPEAT_NEXT_MUL  = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional auto-repeat.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic sync_meta;
  logic sync;
  btn_state_t state_q;
  logic [CntW-1:0] cnt_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RptFirst = BTN_REPEAT_FIRST_MUL * DEBOUNCE_CYCLES;
  localparam int unsigned RptNext  = BTN_REPEAT_NEXT_MUL * DEBOUNCE_CYCLES;
  localparam int unsigned RptW     = $clog2(RptFirst);
  logic [RptW-1:0] rpt_q;
  logic            rpt_armed_q;
  logic [RptW-1:0] rpt_last;
  // Terminal count: long delay before the first repeat, shorter afterwards.
  assign rpt_last = rpt_armed_q ? RptW'(RptNext - 1) : RptW'(RptFirst - 1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta   <= 1'b0;
      sync        <= 1'b0;
      state_q     <= REL;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
      btn_pulse <= 1'b0;
      case (state_q)
        REL: begin
`ifdef BTN_AUTOREPEAT_EN
          rpt_q       <= '0;
          rpt_armed_q <= 1'b0;
`endif
          if (sync) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CntW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state_q <= REL;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= PRS;
            cnt_q     <= '0;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        PRS: begin
          if (!sync) begin
            state_q <= REL_WAIT;
            cnt_q   <= CntW'(1);
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (rpt_q == rpt_last) begin
              btn_pulse   <= 1'b1;
              rpt_q       <= '0;
              rpt_armed_q <= 1'b1;
            end else begin
              rpt_q <= rpt_q + RptW'(1);
            end
`endif
          end
        end
        REL_WAIT: begin
          // Repeat state is held here so a bounce on release does not restart it.
          if (sync) begin
            state_q <= PRS;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= REL;
            cnt_q     <= '0;
            btn_level <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= REL;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounced push-button front end with per-button sticky press flags.
// Define BTN_AUTOREPEAT_EN to enable held-button auto-repeat in each channel.
module btn_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             press_clr,
  input  logic [N_BTN-1:0] press_clr_mask,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_press
);

  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw[g]),
      .btn_level(btn_level[g]),
      .btn_pulse(btn_pulse[g])
    );
  end

  // A pulse landing in the same cycle as a clear keeps the flag set.
  always_comb begin
    press_d = (press_q & ~({N_BTN{press_clr}} & press_clr_mask)) | btn_pulse;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  assign btn_press = press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, N_BTN=5.
module tb_btn_conditioner;

  localparam int unsigned NB = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic          press_clr = 1'b0;
  logic [NB-1:0] press_clr_mask = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_press;

  btn_conditioner #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .press_clr     (press_clr),
    .press_clr_mask(press_clr_mask),
    .btn_level     (btn_level),
    .btn_pulse     (btn_pulse),
    .btn_press     (btn_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] raw;
    logic          clr;
    logic [NB-1:0] mask;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pls;
    logic [NB-1:0] prs;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int n, logic [NB-1:0] raw, logic clr, logic [NB-1:0] mask,
                              logic [NB-1:0] lvl, logic [NB-1:0] pls, logic [NB-1:0] prs);
    vec_t v;
    v.raw = raw; v.clr = clr; v.mask = mask; v.lvl = lvl; v.pls = pls; v.prs = prs;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic void check(string name, logic [NB-1:0] act, logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  initial begin
    logic [NB-1:0] exp_pls;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_level", btn_level, '0);
    check("reset_pulse", btn_pulse, '0);
    check("reset_press", btn_press, '0);
    reset = 1'b1;

    // Clean press, hold, clear, release
    add(5, 5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b00001, 0, 5'b00000, 5'b00001, 5'b00001, 5'b00000);
    add(2, 5'b00001, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00001);
    add(2, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    add(5, 5'b00000, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    add(2, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Glitch of 3 cycles
    add(3, 5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(5, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Clear race: same-cycle clear loses, other-bit mask keeps, next clear wins
    add(5, 5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b00001, 0, 5'b00000, 5'b00001, 5'b00001, 5'b00000);
    add(1, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00001);
    add(1, 5'b00001, 1, 5'b11110, 5'b00001, 5'b00000, 5'b00001);
    add(1, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    add(5, 5'b00000, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    add(2, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Bounce then held high
    for (int i = 0; i < 3; i++) begin
      add(1, 5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
      add(1, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    end
    add(5, 5'b00001, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b00001, 0, 5'b00000, 5'b00001, 5'b00001, 5'b00000);
    add(1, 5'b00001, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00001);
    add(1, 5'b00000, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    add(4, 5'b00000, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    add(2, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Multi-button simultaneous press
    add(5, 5'b10101, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b10101, 0, 5'b00000, 5'b10101, 5'b10101, 5'b00000);
    add(1, 5'b10101, 0, 5'b00000, 5'b10101, 5'b00000, 5'b10101);
    add(1, 5'b00000, 1, 5'b11111, 5'b10101, 5'b00000, 5'b00000);
    add(4, 5'b00000, 0, 5'b00000, 5'b10101, 5'b00000, 5'b00000);
    add(2, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    foreach (vecs[i]) begin
      btn_raw        = vecs[i].raw;
      press_clr      = vecs[i].clr;
      press_clr_mask = vecs[i].mask;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_level", i), btn_level, vecs[i].lvl);
      check($sformatf("vec%0d_pulse", i), btn_pulse, vecs[i].pls);
      check($sformatf("vec%0d_press", i), btn_press, vecs[i].prs);
    end
    press_clr      = 1'b0;
    press_clr_mask = '0;

    // Reset mid-press (bit 2) and mid-wait (bit 1), buttons held through deassertion
    btn_raw = 5'b00100;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_level", btn_level, 5'b00100);
    check("pre_rst_press", btn_press, 5'b00100);
    btn_raw = 5'b00110;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("in_rst_level", btn_level, '0);
    check("in_rst_pulse", btn_pulse, '0);
    check("in_rst_press", btn_press, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Long hold after reset: one press pulse, plus repeats when enabled
    for (int e = 0; e <= 120; e++) begin
      @(posedge clk);
      #1;
      exp_pls = (e == 5) ? 5'b00110 : 5'b00000;
`ifdef BTN_AUTOREPEAT_EN
      if (e == 69 || e == 85 || e == 101) exp_pls = 5'b00110;
`endif
      check($sformatf("hold%0d_pulse", e), btn_pulse, exp_pls);
      check($sformatf("hold%0d_level", e), btn_level, (e >= 5) ? 5'b00110 : 5'b00000);
      check($sformatf("hold%0d_press", e), btn_press, (e >= 6) ? 5'b00110 : 5'b00000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
